rosc_sampler_ctrl: RTL and testbench
====================================

ROSC_SAMPLER_CTRL -- requirements
Module: rosc_sampler_ctrl

Interface
REQ-001 The block SHALL have parameter SEED_CYCLES, default 16: cycles per seed phase (range 2..255).
REQ-002 The block SHALL have parameter RUN_CYCLES, default 64: free-run cycles before each sample (range 2..65535).
REQ-003 The block SHALL have parameter REP_LIMIT, default 32: run length of identical samples that flags a failure (range 2..255).
REQ-004 The block SHALL have port clk, input, 1: the single clock.
REQ-005 The block SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1: start/continue entropy collection.
REQ-007 The block SHALL have port rosc_ctrl, output, 1: oscillator seed-mode select, 1 = seeded/stopped, 0 = free-running.
REQ-008 The block SHALL have port rosc_seed, output, 1: seed value driven into all oscillator stages.
REQ-009 The block SHALL have port rosc_d, input, 1: oscillator output, asynchronous to clk.
REQ-010 The block SHALL have port data, output, 8: collected entropy byte.
REQ-011 The block SHALL have port data_valid, output, 1: data holds a new byte.
REQ-012 The block SHALL have port data_ack, input, 1: consumer accepts the byte.
REQ-013 The block SHALL have port error, output, 1: sticky health-test failure.

Function
REQ-014 The block SHALL pass rosc_d through a two-flop synchronizer; the sampled bit SHALL be the synchronizer output only.
REQ-015 The FSM SHALL have states IDLE, SEED, RUN, OUT, FAIL.
REQ-016 In IDLE: rosc_ctrl=1. Transition to SEED when enable=1 and error=0.
REQ-017 In SEED: rosc_ctrl=1 for exactly SEED_CYCLES cycles. rosc_seed SHALL invert on each SEED entry. Then go to RUN.
REQ-018 In RUN: rosc_ctrl=0 for exactly RUN_CYCLES cycles. On the last RUN cycle, shift the synchronized bit into the LSB of an 8-bit shift register, MSB-first, and increment a 3-bit bit counter.
REQ-019 After RUN, if 8 bits have been collected (counter wrapped 7->0), load data and go to OUT. Otherwise go to SEED.
REQ-020 In OUT: data_valid=1, data is stable, and rosc_ctrl=1. The byte is accepted on a cycle with data_ack=1, which SHALL clear data_valid on the next cycle. Then go to SEED if enable=1, else IDLE.
REQ-021 data_ack while data_valid=0 SHALL be ignored.
REQ-022 When enable=0 in SEED or RUN: go to IDLE on the next cycle, and clear the shift register and bit counter (partial byte discarded).
REQ-023 When enable=0 in OUT: hold OUT until data_ack.
REQ-024 Health test: a repetition counter SHALL count consecutive identical samples, resetting to 1 on a change.
REQ-025 When the repetition counter reaches REP_LIMIT, set error=1 and go to FAIL. Any partial byte SHALL be discarded and data_valid SHALL not assert.
REQ-026 In FAIL: rosc_ctrl=1, data_valid=0. Exit only by reset.
REQ-027 Latency from enable rising in IDLE to data_valid SHALL be 1 + 8*(SEED_CYCLES+RUN_CYCLES) cycles.

Reset
REQ-028 While reset_n=0: state=IDLE, rosc_ctrl=1, rosc_seed=0, data=0, data_valid=0, error=0, all counters and the synchronizer cleared.
REQ-029 Asserting reset_n=0 mid-operation SHALL abort immediately; no byte SHALL be delivered from pre-reset samples.

Structure
REQ-030 FSM state encodings and the counter width constants SHALL live in the shared rosc_pkg package.
REQ-031 The synchronizer SHALL be the sub-module sync2, with ports clk, reset_n, d_in, d_out.
REQ-032 The oscillator SHALL remain a separate instance outside this block.

Verification
(Bench parameters: SEED_CYCLES=4, RUN_CYCLES=8, REP_LIMIT=8; bench drives rosc_d.)
REQ-033 Reset -> rosc_ctrl=1, data_valid=0, error=0.
REQ-034 enable=1 and rosc_d set to each bit of 1,0,1,1,0,0,1,0 at successive sample points -> data=8'hB2 and data_valid=1 at cycle 97.
REQ-035 data_valid high with data_ack withheld for 20 cycles -> data stable and rosc_ctrl=1 throughout. Then data_ack pulse -> data_valid=0 on the next cycle and SEED re-entered.
REQ-036 enable dropped after 5 samples -> IDLE next cycle. Re-enable -> the next byte contains only new samples.
REQ-037 rosc_d held at 1 -> error=1 after the 8th sample, FSM enters FAIL, and data_valid never asserts. Only reset_n clears error.
REQ-038 reset_n pulsed low in mid-RUN -> outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/rosc_pkg.sv
// Shared definitions for the ring-oscillator sampler controller.
//   rosc_state_e : FSM state encoding (IDLE, SEED, RUN, OUT, FAIL)
//   *_W          : counter and data widths used by rosc_sampler_ctrl
package rosc_pkg;

    // Wide enough for RUN_CYCLES up to 65535 and SEED_CYCLES up to 255.
    localparam int unsigned PHASE_CNT_W = 16;
    // Wide enough for REP_LIMIT up to 255.
    localparam int unsigned REP_CNT_W   = 8;
    // Eight samples per byte: a 3-bit counter wraps 7 -> 0 on completion.
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned DATA_W      = 8;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSeed = 3'd1,
        StRun  = 3'd2,
        StOut  = 3'd3,
        StFail = 3'd4
    } rosc_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears both stages
//   d_in    : asynchronous input
//   d_out   : synchronized output (two clk cycles of latency)
module sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_in,
    output logic d_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign d_out = r_sync;

endmodule

// File: rtl/rosc_sampler_ctrl.sv
// Ring-oscillator entropy sampler controller.
// Repeatedly seeds the external oscillator, lets it free-run, samples one bit,
// and assembles eight samples (first sample in the MSB) into a byte handed to
// the consumer with a valid/ack pair. A repetition-count health test latches a
// sticky error and parks the FSM in FAIL until reset.
//   clk        : single clock
//   reset_n    : asynchronous active-low reset
//   enable     : start/continue entropy collection
//   rosc_ctrl  : 1 = oscillator seeded/stopped, 0 = free-running
//   rosc_seed  : seed value for all oscillator stages, inverts on each SEED entry
//   rosc_d     : oscillator output, asynchronous to clk
//   data       : collected entropy byte
//   data_valid : data holds a new byte
//   data_ack   : consumer accepts the byte
//   error      : sticky health-test failure
module rosc_sampler_ctrl
    import rosc_pkg::*;
#(
    parameter int unsigned SEED_CYCLES = 16,
    parameter int unsigned RUN_CYCLES  = 64,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic              rosc_ctrl,
    output logic              rosc_seed,
    input  logic              rosc_d,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ack,
    output logic              error
);

    rosc_state_e r_state;
    rosc_state_e w_state_next;

    logic [PHASE_CNT_W-1:0] r_phase_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_data;
    logic [REP_CNT_W-1:0]   r_rep_cnt;
    logic                   r_last_bit;
    logic                   r_error;
    logic                   r_seed;

    logic                   w_bit;
    logic                   w_seed_last;
    logic                   w_run_last;
    logic                   w_sample;
    logic                   w_byte_done;
    logic [REP_CNT_W-1:0]   w_rep_next;
    logic                   w_rep_fail;
    logic                   w_discard;

    sync2 u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d_in    (rosc_d),
        .d_out   (w_bit)
    );

    assign w_seed_last = (r_phase_cnt == PHASE_CNT_W'(SEED_CYCLES - 1));
    assign w_run_last  = (r_phase_cnt == PHASE_CNT_W'(RUN_CYCLES - 1));
    // A sample is taken only on the final RUN cycle of an uninterrupted round.
    assign w_sample    = (r_state == StRun) && enable && w_run_last;
    assign w_byte_done = (r_bit_cnt == {BIT_CNT_W{1'b1}});

    // Run length restarts at 1 on the very first sample and on any change.
    always_comb begin
        w_rep_next = REP_CNT_W'(1);
        if (r_rep_cnt != '0 && w_bit == r_last_bit) begin
            w_rep_next = r_rep_cnt + REP_CNT_W'(1);
        end
    end

    assign w_rep_fail = w_sample && (w_rep_next == REP_CNT_W'(REP_LIMIT));

    // Partial byte is dropped on an enable abort or a health-test failure.
    assign w_discard = (!enable && (r_state == StSeed || r_state == StRun)) || w_rep_fail;

    // ---------------------------------------------------------------- FSM state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (enable && !r_error) begin
                    w_state_next = StSeed;
                end
            end
            StSeed: begin
                if (!enable) begin
                    w_state_next = StIdle;
                end else if (w_seed_last) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (!enable) begin
                    w_state_next = StIdle;
                end else if (w_run_last) begin
                    // Health failure wins over delivering the completed byte.
                    if (w_rep_fail) begin
                        w_state_next = StFail;
                    end else if (w_byte_done) begin
                        w_state_next = StOut;
                    end else begin
                        w_state_next = StSeed;
                    end
                end
            end
            StOut: begin
                if (data_ack) begin
                    w_state_next = enable ? StSeed : StIdle;
                end
            end
            StFail: begin
                w_state_next = StFail;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        rosc_ctrl  = 1'b1;
        data_valid = 1'b0;
        unique case (r_state)
            StRun:   rosc_ctrl  = 1'b0;
            StOut:   data_valid = 1'b1;
            default: ;
        endcase
    end

    assign rosc_seed = r_seed;
    assign data      = r_data;
    assign error     = r_error;

    // ---------------------------------------------------------------- datapath
    // Phase counter restarts on every state change and only runs in SEED/RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_phase_cnt <= '0;
        end else if (r_state == StSeed || r_state == StRun) begin
            r_phase_cnt <= r_phase_cnt + PHASE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_discard) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_shift   <= {r_shift[DATA_W-2:0], w_bit};
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (w_sample && w_byte_done && !w_rep_fail) begin
            r_data <= {r_shift[DATA_W-2:0], w_bit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rep_cnt  <= '0;
            r_last_bit <= 1'b0;
        end else if (w_sample) begin
            r_rep_cnt  <= w_rep_next;
            r_last_bit <= w_bit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else if (w_rep_fail) begin
            r_error <= 1'b1;
        end
    end

    // Alternating the seed each round avoids the oscillator restarting from
    // the same frozen state every time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seed <= 1'b0;
        end else if (w_state_next == StSeed && r_state != StSeed) begin
            r_seed <= ~r_seed;
        end
    end

endmodule

// File: tb/tb_rosc_sampler_ctrl.sv
// Directed self-checking bench for rosc_sampler_ctrl (SEED=4, RUN=8, REP_LIMIT=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rosc_sampler_ctrl;

    localparam int S = 4;
    localparam int R = 8;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       rosc_ctrl;
    logic       rosc_seed;
    logic       rosc_d;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ack;
    logic       error;

    int   n_tests;
    int   n_fail;
    logic exp_seed;

    rosc_sampler_ctrl #(
        .SEED_CYCLES (S),
        .RUN_CYCLES  (R),
        .REP_LIMIT   (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .rosc_ctrl  (rosc_ctrl),
        .rosc_seed  (rosc_seed),
        .rosc_d     (rosc_d),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        data_ack = 1'b0;
        rosc_d   = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        exp_seed = 1'b0;
        @(negedge clk);
    endtask

    // One round per sample: set the bit, then step through SEED and RUN checking
    // the oscillator control, seed parity and that no byte appears early.
    task automatic drive_samples(input logic [7:0] bits, input int n, input logic ack_noise);
        logic exp_ctrl;
        for (int k = 0; k < n; k++) begin
            rosc_d   = bits[7-k];
            data_ack = ack_noise & k[0];
            exp_seed = ~exp_seed;
            for (int j = 1; j <= S + R; j++) begin
                @(negedge clk);
                exp_ctrl = (j <= S);
                n_tests++;
                if (rosc_ctrl !== exp_ctrl) begin
                    n_fail++;
                    $display("FAIL round_ctrl k=%0d j=%0d: got %b want %b", k, j, rosc_ctrl, exp_ctrl);
                end
                n_tests++;
                if (rosc_seed !== exp_seed) begin
                    n_fail++;
                    $display("FAIL round_seed k=%0d j=%0d: got %b want %b", k, j, rosc_seed, exp_seed);
                end
                n_tests++;
                if (data_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL round_valid k=%0d j=%0d: got %b want 0", k, j, data_valid);
                end
            end
        end
        data_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        data_ack = 1'b0;
        rosc_d   = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (rosc_ctrl !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl: got %b want 1", rosc_ctrl); end
        n_tests++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_tests++;
        if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
        n_tests++;
        if (rosc_seed !== 1'b0) begin n_fail++; $display("FAIL reset_seed: got %b want 0", rosc_seed); end
        reset_n  = 1'b1;
        exp_seed = 1'b0;
        // Ack with nothing valid must leave the idle block untouched.
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if (data_valid !== 1'b0 || rosc_ctrl !== 1'b1 || rosc_seed !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack: got valid=%b ctrl=%b seed=%b want 0 1 0", data_valid, rosc_ctrl, rosc_seed);
        end
    endtask

    // 1,0,1,1,0,0,1,0 first-in-MSB -> 8'hB2, valid 97 cycles after enable.
    task automatic test_byte();
        enable = 1'b1;
        drive_samples(8'hB2, 8, 1'b1);
        @(negedge clk);
        n_tests++;
        if (data_valid !== 1'b1) begin n_fail++; $display("FAIL byte_valid@97: got %b want 1", data_valid); end
        n_tests++;
        if (data !== 8'hB2) begin n_fail++; $display("FAIL byte_data: got %h want b2", data); end
        n_tests++;
        if (rosc_ctrl !== 1'b1) begin n_fail++; $display("FAIL byte_ctrl: got %b want 1", rosc_ctrl); end
    endtask

    task automatic test_out_hold();
        for (int i = 0; i < 20; i++) begin
            rosc_d = i[1];
            @(negedge clk);
            n_tests++;
            if (data_valid !== 1'b1 || data !== 8'hB2 || rosc_ctrl !== 1'b1) begin
                n_fail++;
                $display("FAIL hold i=%0d: got valid=%b data=%h ctrl=%b want 1 b2 1", i, data_valid, data, rosc_ctrl);
            end
        end
        data_ack = 1'b1;
        exp_seed = ~exp_seed;
        @(negedge clk);
        data_ack = 1'b0;
        n_tests++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b want 0", data_valid); end
        n_tests++;
        if (rosc_ctrl !== 1'b1 || rosc_seed !== exp_seed) begin
            n_fail++;
            $display("FAIL ack_reseed: got ctrl=%b seed=%b want 1 %b", rosc_ctrl, rosc_seed, exp_seed);
        end
        repeat (S) @(negedge clk);
        n_tests++;
        if (rosc_ctrl !== 1'b0) begin n_fail++; $display("FAIL ack_run: got %b want 0", rosc_ctrl); end
        enable = 1'b0;
        @(negedge clk);
    endtask

    // Five samples, abort mid-RUN, then a fresh byte 0,1,1,0,1,0,0,1 = 8'h69.
    task automatic test_abort();
        apply_reset();
        enable = 1'b1;
        drive_samples(8'hC8, 5, 1'b0);
        exp_seed = ~exp_seed;
        repeat (S + 2) @(negedge clk);
        n_tests++;
        if (rosc_ctrl !== 1'b0) begin n_fail++; $display("FAIL abort_inrun: got %b want 0", rosc_ctrl); end
        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rosc_ctrl !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got %b want 1", rosc_ctrl); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (rosc_seed !== exp_seed || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_hold: got seed=%b valid=%b want %b 0", rosc_seed, data_valid, exp_seed);
        end
        enable = 1'b1;
        drive_samples(8'h69, 8, 1'b0);
        @(negedge clk);
        n_tests++;
        if (data_valid !== 1'b1 || data !== 8'h69) begin
            n_fail++;
            $display("FAIL abort_newbyte: got valid=%b data=%h want 1 69", data_valid, data);
        end
        enable   = 1'b0;
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    // Constant 1: eighth identical sample trips the health test, no byte out.
    task automatic test_health_fail();
        apply_reset();
        enable = 1'b1;
        drive_samples(8'hFF, 8, 1'b0);
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL health_early: got %b want 0", error); end
        @(negedge clk);
        n_tests++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL health_error: got %b want 1", error); end
        for (int i = 0; i < 20; i++) begin
            enable = (i >= 5 && i < 10) ? 1'b0 : 1'b1;
            data_ack = i[0];
            @(negedge clk);
            n_tests++;
            if (data_valid !== 1'b0 || error !== 1'b1 || rosc_ctrl !== 1'b1 || rosc_seed !== exp_seed) begin
                n_fail++;
                $display("FAIL fail_state i=%0d: got valid=%b err=%b ctrl=%b seed=%b want 0 1 1 %b",
                         i, data_valid, error, rosc_ctrl, rosc_seed, exp_seed);
            end
        end
        data_ack = 1'b0;
        enable   = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_tests++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL fail_reset: got %b want 0", error); end
        @(negedge clk);
        reset_n  = 1'b1;
        exp_seed = 1'b0;
        @(negedge clk);
    endtask

    // Reset mid-RUN must clear outputs before the next clock edge.
    task automatic test_async_reset();
        apply_reset();
        enable   = 1'b1;
        rosc_d   = 1'b1;
        exp_seed = 1'b1;
        repeat (S + 2) @(negedge clk);
        n_tests++;
        if (rosc_ctrl !== 1'b0 || rosc_seed !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got ctrl=%b seed=%b want 0 1", rosc_ctrl, rosc_seed);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (rosc_ctrl !== 1'b1 || data_valid !== 1'b0 || error !== 1'b0 || rosc_seed !== 1'b0 ||
            data !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_now: got ctrl=%b valid=%b err=%b seed=%b data=%h want 1 0 0 0 00",
                     rosc_ctrl, data_valid, error, rosc_seed, data);
        end
        @(negedge clk);
        reset_n  = 1'b1;
        exp_seed = 1'b0;
        drive_samples(8'hC5, 8, 1'b0);
        @(negedge clk);
        n_tests++;
        if (data_valid !== 1'b1 || data !== 8'hC5) begin
            n_fail++;
            $display("FAIL areset_newbyte: got valid=%b data=%h want 1 c5", data_valid, data);
        end
        enable = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_seed = 1'b0;
        test_reset();
        test_byte();
        test_out_hold();
        test_abort();
        test_health_fail();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
